// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transmit FSM states and byte-level constants.
package i2c_pkg;

    localparam int         I2C_BYTE_BITS    = 8;
    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        ACK_WAIT = 2'd2,
        ACK_HOLD = 2'd3
    } tx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps to zero after reaching rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_out = count_q;

endmodule

// File: rtl/i2c_tx_serializer.sv
// Slave-side I2C transmit serializer: pops tx_fifo bytes and shifts them MSB-first
// onto SDA on SCL falling edges, then samples the master's ACK/NACK.
module i2c_tx_serializer
    import i2c_pkg::*;
#(
    parameter int                    DATA_WIDTH = I2C_BYTE_BITS,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = PAD_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  scl_rise,
    input  logic                  scl_fall,
    input  logic                  sda_in,
    input  logic                  tx_start,
    input  logic                  stop_found,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_enable,
    output logic                  sda_out,
    output logic                  busy,
    output logic                  ack_rcvd,
    output logic                  nack_rcvd,
    output logic                  underrun
);

    localparam int         CNT_BITS = 4;
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  sda_q, sda_d;
    logic                  re_q, re_d;
    logic                  ack_q, ack_d;
    logic                  nack_q, nack_d;
    logic                  und_q, und_d;
    logic                  busy_q, busy_d;

    logic                  load;
    logic                  cnt_clear;
    logic                  cnt_en;
    logic [CNT_BITS-1:0]   bit_cnt;

    flex_counter #(
        .NUM_CNT_BITS(CNT_BITS)
    ) u_bit_cnt (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (cnt_clear),
        .count_enable(cnt_en),
        .rollover_val(LAST_BIT),
        .count_out   (bit_cnt)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        re_d      = 1'b0;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        und_d     = 1'b0;
        load      = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        // STOP / repeated START overrides every other event this cycle.
        if (stop_found) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_start) load = 1'b1;
                end
                SHIFT: begin
                    if (scl_fall) begin
                        if (bit_cnt < LAST_BIT) begin
                            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                            cnt_en  = 1'b1;
                        end else begin
                            state_d = ACK_WAIT;
                        end
                    end
                end
                ACK_WAIT: begin
                    // A coincident fall masks the rise so the slot is never sampled twice.
                    if (scl_rise && !scl_fall) begin
                        if (!sda_in) begin
                            ack_d   = 1'b1;
                            state_d = ACK_HOLD;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                ACK_HOLD: begin
                    if (scl_fall) load = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                state_d   = SHIFT;
                cnt_clear = 1'b1;
                if (!fifo_empty) begin
                    shift_d = read_data;
                    re_d    = 1'b1;
                end else begin
                    shift_d = PAD_BYTE;
                    und_d   = 1'b1;
                end
            end
        end

        // SDA is registered from the next-state view so each bit appears one clk after scl_fall.
        sda_d  = (state_d == SHIFT) ? shift_d[DATA_WIDTH-1] : 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            sda_q   <= 1'b1;
            re_q    <= 1'b0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            und_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            sda_q   <= sda_d;
            re_q    <= re_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            und_q   <= und_d;
            busy_q  <= busy_d;
        end
    end

    assign read_enable = re_q;
    assign sda_out     = sda_q;
    assign busy        = busy_q;
    assign ack_rcvd    = ack_q;
    assign nack_rcvd   = nack_q;
    assign underrun    = und_q;

endmodule

// File: tb/tb_i2c_tx_serializer.sv
// Bench for i2c_tx_serializer: acts as I2C master and as tx_fifo, checks bytes seen on SDA.
module tb_i2c_tx_serializer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       scl_rise, scl_fall, sda_in, tx_start, stop_found;
    logic       fifo_empty;
    logic [7:0] read_data;
    logic       read_enable, sda_out, busy, ack_rcvd, nack_rcvd, underrun;

    int total = 0;
    int bad   = 0;

    // tx_fifo stand-in: first-word fall-through, pops on a sampled read_enable
    logic [7:0] mem [16];
    int         wr = 0;
    int         rd = 0;
    int         re_cnt = 0;
    int         und_cnt = 0;

    assign fifo_empty = (rd == wr);
    assign read_data  = mem[rd[3:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read_enable) begin
            rd     <= rd + 1;
            re_cnt <= re_cnt + 1;
        end
        if (underrun) und_cnt <= und_cnt + 1;
    end

    i2c_tx_serializer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .sda_in     (sda_in),
        .tx_start   (tx_start),
        .stop_found (stop_found),
        .fifo_empty (fifo_empty),
        .read_data  (read_data),
        .read_enable(read_enable),
        .sda_out    (sda_out),
        .busy       (busy),
        .ack_rcvd   (ack_rcvd),
        .nack_rcvd  (nack_rcvd),
        .underrun   (underrun)
    );

    typedef struct {
        logic       has;
        logic [7:0] data;
        logic       nack;
        logic [7:0] exp_byte;
        logic       exp_und;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] mq [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr++;
    endtask

    task automatic start();
        tx_start = 1'b1; tick(); tx_start = 1'b0;
    endtask

    task automatic stop();
        stop_found = 1'b1; tick(); stop_found = 1'b0;
    endtask

    task automatic fall();
        scl_fall = 1'b1; tick(); scl_fall = 1'b0;
    endtask

    // n SCL clocks; SDA is sampled in the middle of each high window
    task automatic shift_bits(input int n, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            tick(); tick();
            scl_rise = 1'b1; tick(); scl_rise = 1'b0;
            got = {got[6:0], sda_out};
            tick();
            fall();
        end
    endtask

    task automatic ack_phase(input logic nack, output logic a, output logic n);
        tick();
        sda_in = nack;
        scl_rise = 1'b1; tick(); scl_rise = 1'b0;
        a = ack_rcvd;
        n = nack_rcvd;
        sda_in = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] got, g1, g2, e;
        logic       a, n;
        int         b_re, b_u, ep, eu, nb, np;

        n_rst = 1'b0; scl_rise = 0; scl_fall = 0; sda_in = 1; tx_start = 0; stop_found = 0;
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{1'b0, 8'h12, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{1'b1, 8'h01, 1'b0, 8'h01, 1'b0};

        repeat (3) tick();
        check("rst_sda", sda_out, 1);
        check("rst_busy", busy, 0);
        check("rst_re", read_enable, 0);
        check("rst_acks", {ack_rcvd, nack_rcvd, underrun}, 0);
        n_rst = 1'b1;
        tick();

        // table: one byte per transfer, ACK ends via STOP, NACK via final fall
        for (int v = 0; v < 7; v++) begin
            b_re = re_cnt; b_u = und_cnt;
            if (vecs[v].has) fifo_push(vecs[v].data);
            start();
            check($sformatf("v%0d_msb", v), sda_out, vecs[v].exp_byte[7]);
            check($sformatf("v%0d_und_pulse", v), underrun, vecs[v].exp_und);
            shift_bits(8, got);
            check($sformatf("v%0d_byte", v), got, vecs[v].exp_byte);
            check($sformatf("v%0d_rel", v), sda_out, 1);
            ack_phase(vecs[v].nack, a, n);
            check($sformatf("v%0d_ack", v), {a, n}, {~vecs[v].nack, vecs[v].nack});
            if (vecs[v].nack) fall(); else stop();
            tick();
            check($sformatf("v%0d_pops", v), re_cnt - b_re, {31'd0, ~vecs[v].exp_und});
            check($sformatf("v%0d_unds", v), und_cnt - b_u, {31'd0, vecs[v].exp_und});
            check($sformatf("v%0d_idle", v), busy, 0);
        end

        // two-byte read, tx_start mid-byte must be ignored
        b_re = re_cnt;
        fifo_push(8'h3C); fifo_push(8'hC3);
        start();
        check("ab_re", read_enable, 1);
        shift_bits(4, g1);
        start();
        shift_bits(4, g2);
        check("ab_b0", {g1[3:0], g2[3:0]}, 8'h3C);
        ack_phase(1'b0, a, n);
        check("ab_ack0", {a, n}, 2'b10);
        fall();
        check("ab_re2", read_enable, 1);
        shift_bits(8, got);
        check("ab_b1", got, 8'hC3);
        ack_phase(1'b1, a, n);
        check("ab_nack1", {a, n}, 2'b01);
        fall(); tick();
        check("ab_end", {sda_out, busy, fifo_empty}, 3'b101);
        check("ab_pops", re_cnt - b_re, 2);

        // STOP after 4 bits of 8'h0F, then restart sends the next byte from its MSB
        fifo_push(8'h0F); fifo_push(8'h5A);
        start();
        shift_bits(4, got);
        check("stp_bits", got[3:0], 4'h0);
        check("stp_low", sda_out, 1);
        stop();
        check("stp_rel", {sda_out, busy}, 2'b10);
        repeat (3) tick();
        start();
        check("stp_msb", sda_out, 0);
        shift_bits(8, got);
        check("stp_next", got, 8'h5A);
        ack_phase(1'b1, a, n);
        fall(); tick();

        // coincident rise+fall in the ACK slot must not sample
        fifo_push(8'h96);
        start();
        shift_bits(8, got);
        check("rf_byte", got, 8'h96);
        tick();
        sda_in = 1'b0; scl_rise = 1'b1; scl_fall = 1'b1;
        tick();
        scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b1;
        check("rf_noack", {ack_rcvd, nack_rcvd, busy, sda_out}, 4'b0011);
        ack_phase(1'b0, a, n);
        check("rf_ack", {a, n}, 2'b10);
        stop(); tick();

        // reset mid-byte: 8'h55 already popped, re-run sends 8'hAA
        fifo_push(8'h55); fifo_push(8'hAA);
        start();
        shift_bits(2, got);
        check("rs_lowbit", sda_out, 0);
        n_rst = 1'b0;
        #1;
        check("rs_async", {sda_out, busy, read_enable, ack_rcvd, nack_rcvd, underrun}, 6'b100000);
        tick(); tick();
        n_rst = 1'b1;
        tick();
        start();
        shift_bits(8, got);
        check("rs_byte", got, 8'hAA);
        ack_phase(1'b1, a, n);
        fall(); tick();

        // random multi-byte transfers against a queue model of the FIFO contents
        for (int t = 0; t < 15; t++) begin
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) begin
                e = 8'($urandom);
                fifo_push(e);
                mq.push_back(e);
            end
            nb = $urandom_range(1, 4);
            b_re = re_cnt; b_u = und_cnt; ep = 0; eu = 0;
            start();
            for (int k = 0; k < nb; k++) begin
                shift_bits(8, got);
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    ep++;
                end else begin
                    e = 8'hFF;
                    eu++;
                end
                check($sformatf("r%0d_b%0d", t, k), got, e);
                ack_phase(k == nb - 1, a, n);
                check($sformatf("r%0d_a%0d", t, k), {a, n}, (k == nb - 1) ? 2'b01 : 2'b10);
                fall();
            end
            tick();
            check($sformatf("r%0d_pops", t), re_cnt - b_re, ep);
            check($sformatf("r%0d_unds", t), und_cnt - b_u, eu);
            check($sformatf("r%0d_idle", t), {busy, sda_out}, 2'b01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
